// File: rtl/m2s_request_tracker.sv
// m2s_request_tracker: arbitrates NUM_CH request channels onto one m2s memory
// port, tags each request with a free transaction ID, and routes the tagged
// responses back to the originating channel. An INIT/RUN/DRAIN/DONE
// controller sequences start-up and an orderly drain before finalisation.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_INIT  | one idle cycle after reset release, no grants
//   S_RUN   | normal operation, grants allowed
//   S_DRAIN | no new grants, waiting for outstanding IDs and issue register
//   S_DONE  | drain complete, drain_done high until reset
module m2s_request_tracker #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 31,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          ch_req_valid,
   output logic [NUM_CH-1:0]          ch_req_ready,
   input  logic [NUM_CH-1:0]          ch_req_rw,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr,
   input  logic [NUM_CH*DATA_W-1:0]   ch_req_data,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic [ADDR_W+DATA_W:0]     mem_req,
   output logic [ID_W-1:0]            mem_req_id,
   input  logic                       mem_rsp_valid,
   input  logic [ID_W-1:0]            mem_rsp_id,
   input  logic [DATA_W-1:0]          mem_rsp_data,
   output logic [NUM_CH-1:0]          ch_rsp_valid,
   output logic [DATA_W-1:0]          ch_rsp_data,
   output logic                       ch_rsp_rw,
   output logic [ID_W:0]              outstanding_count,
   output logic [ID_W-1:0]            next_id_available_out,
   output logic                       id_available,
   input  logic                       drain_req,
   output logic                       drain_done,
   output logic                       err_spurious_rsp
);

   localparam int DEPTH = 1 << ID_W;
   localparam int CH_W  = $clog2(NUM_CH);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_grant_en;
   logic                    w_drain_done_nxt;

   logic [DEPTH-1:0]        r_busy;
   logic [DEPTH-1:0]        w_busy_nxt;
   logic [ID_W:0]           w_busy_cnt;
   logic [ID_W:0]           r_count;
   logic [CH_W-1:0]         r_tab_ch [DEPTH];
   logic                    r_tab_rw [DEPTH];
   logic [ID_W-1:0]         w_free_id;

   logic [CH_W-1:0]         r_rr_ptr;
   logic [CH_W-1:0]         w_gnt_idx;
   logic                    w_gnt_found;
   logic                    w_issue_ok;
   logic                    w_accept;
   logic                    w_rsp_hit;

   logic                    r_mem_req_valid;
   logic [ADDR_W+DATA_W:0]  r_mem_req;
   logic [ID_W-1:0]         r_mem_req_id;
   logic [NUM_CH-1:0]       r_ch_rsp_valid;
   logic [DATA_W-1:0]       r_ch_rsp_data;
   logic                    r_ch_rsp_rw;
   logic                    r_drain_done;
   logic                    r_err;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_INIT;
      else        r_state <= w_state_nxt;
   end

   // FSM next-state logic; drain completes once the table and issue register are empty
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  w_state_nxt = S_RUN;
         S_RUN:   if (drain_req) w_state_nxt = S_DRAIN;
         S_DRAIN: if ((r_busy == '0) && !r_mem_req_valid) w_state_nxt = S_DONE;
         default: w_state_nxt = S_DONE;
      endcase
   end

   // FSM outputs; the cycle drain_req is seen high already blocks grants
   always_comb begin
      w_grant_en       = (r_state == S_RUN) && !drain_req;
      w_drain_done_nxt = (w_state_nxt == S_DONE);
   end

   // lowest free ID taken from the registered busy vector
   always_comb begin
      w_free_id = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_busy[i]) w_free_id = ID_W'(i);
      end
   end

   assign id_available          = ~&r_busy;
   assign next_id_available_out = w_free_id;
   assign w_issue_ok            = w_grant_en && id_available && (!r_mem_req_valid || mem_req_ready);

   // round-robin search for the first valid channel at or after the pointer
   always_comb begin
      int w_idx;
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_idx       = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_idx = int'(r_rr_ptr) + i;
         if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
         if (!w_gnt_found && ch_req_valid[w_idx]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = CH_W'(w_idx);
         end
      end
   end

   assign w_accept     = w_issue_ok && w_gnt_found;
   assign ch_req_ready = w_accept ? (NUM_CH'(1) << w_gnt_idx) : '0;
   assign w_rsp_hit    = mem_rsp_valid && r_busy[mem_rsp_id];

   // busy vector update; the allocated and freed IDs can never coincide
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_accept)  w_busy_nxt[w_free_id]  = 1'b1;
      if (w_rsp_hit) w_busy_nxt[mem_rsp_id] = 1'b0;
      w_busy_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_busy_cnt = w_busy_cnt + (ID_W+1)'(w_busy_nxt[i]);
      end
   end

   // busy vector, its popcount, and the round-robin pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy   <= '0;
         r_count  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_count <= w_busy_cnt;
         if (w_accept) r_rr_ptr <= (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
      end
   end

   // outstanding table payload; only meaningful while the matching busy bit is set
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tab_ch[w_free_id] <= w_gnt_idx;
         r_tab_rw[w_free_id] <= ch_req_rw[w_gnt_idx];
      end
   end

   // issue register: loads on acceptance, empties on handshake, holds under backpressure
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mem_req_valid <= 1'b0;
         r_mem_req       <= '0;
         r_mem_req_id    <= '0;
      end else if (w_accept) begin
         r_mem_req_valid <= 1'b1;
         r_mem_req       <= {ch_req_rw[w_gnt_idx],
                             ch_req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W],
                             ch_req_data[int'(w_gnt_idx)*DATA_W +: DATA_W]};
         r_mem_req_id    <= w_free_id;
      end else if (mem_req_ready) begin
         r_mem_req_valid <= 1'b0;
      end
   end

   // response routing, sticky spurious-response flag and drain_done
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ch_rsp_valid <= '0;
         r_ch_rsp_data  <= '0;
         r_ch_rsp_rw    <= 1'b0;
         r_err          <= 1'b0;
         r_drain_done   <= 1'b0;
      end else begin
         r_ch_rsp_valid <= w_rsp_hit ? (NUM_CH'(1) << r_tab_ch[mem_rsp_id]) : '0;
         if (w_rsp_hit) begin
            r_ch_rsp_data <= mem_rsp_data;
            r_ch_rsp_rw   <= r_tab_rw[mem_rsp_id];
         end
         if (mem_rsp_valid && !r_busy[mem_rsp_id]) r_err <= 1'b1;
         r_drain_done <= w_drain_done_nxt;
      end
   end

   assign mem_req_valid     = r_mem_req_valid;
   assign mem_req           = r_mem_req;
   assign mem_req_id        = r_mem_req_id;
   assign ch_rsp_valid      = r_ch_rsp_valid;
   assign ch_rsp_data       = r_ch_rsp_data;
   assign ch_rsp_rw         = r_ch_rsp_rw;
   assign outstanding_count = r_count;
   assign drain_done        = r_drain_done;
   assign err_spurious_rsp  = r_err;

endmodule

// File: tb/tb_m2s_request_tracker.sv
// Bench for m2s_request_tracker: directed scenarios plus a randomized run.
// A transaction-level model predicts grants, issued requests and routed
// responses; a separate monitor pops the predictions when the DUT presents them.
module tb_m2s_request_tracker;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 31;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
   localparam int DEPTH  = 16;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [NUM_CH-1:0]         ch_req_valid = '0;
   logic [NUM_CH-1:0]         ch_req_ready;
   logic [NUM_CH-1:0]         ch_req_rw = '0;
   logic [NUM_CH*ADDR_W-1:0]  ch_req_addr = '0;
   logic [NUM_CH*DATA_W-1:0]  ch_req_data = '0;
   logic                      mem_req_valid;
   logic                      mem_req_ready = 1'b0;
   logic [ADDR_W+DATA_W:0]    mem_req;
   logic [ID_W-1:0]           mem_req_id;
   logic                      mem_rsp_valid = 1'b0;
   logic [ID_W-1:0]           mem_rsp_id = '0;
   logic [DATA_W-1:0]         mem_rsp_data = '0;
   logic [NUM_CH-1:0]         ch_rsp_valid;
   logic [DATA_W-1:0]         ch_rsp_data;
   logic                      ch_rsp_rw;
   logic [ID_W:0]             outstanding_count;
   logic [ID_W-1:0]           next_id_available_out;
   logic                      id_available;
   logic                      drain_req = 1'b0;
   logic                      drain_done;
   logic                      err_spurious_rsp;

   m2s_request_tracker #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset),
      .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_rw(ch_req_rw),
      .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req(mem_req), .mem_req_id(mem_req_id),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data),
      .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data), .ch_rsp_rw(ch_rsp_rw),
      .outstanding_count(outstanding_count), .next_id_available_out(next_id_available_out),
      .id_available(id_available), .drain_req(drain_req), .drain_done(drain_done),
      .err_spurious_rsp(err_spurious_rsp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // staged stimulus, applied at the next falling edge
   logic              d_reset = 1'b0;
   logic [3:0]        d_valid = '0;
   logic [3:0]        d_rw = '0;
   logic [30:0]       d_addr [4];
   logic [31:0]       d_data [4];
   logic              d_ready = 1'b1;
   logic              d_rsp_valid = 1'b0;
   logic [3:0]        d_rsp_id = '0;
   logic [31:0]       d_rsp_data = '0;
   logic              d_drain = 1'b0;

   // reference model: phase 0 init, 1 run, 2 drain, 3 done
   int                m_phase = 0;
   bit                m_busy [DEPTH];
   int                m_ch [DEPTH];
   bit                m_rw [DEPTH];
   int                m_ptr = 0;
   bit                m_full = 0;
   bit                m_err = 0;
   bit                m_was_reset = 0;
   int                n_grants = 0;

   typedef struct { logic [63:0] req; logic [3:0] id; } req_t;
   typedef struct { int ch; logic rw; logic [31:0] data; int due; } rsp_t;
   req_t q_req [$];
   rsp_t q_rsp [$];

   function automatic int nbusy();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
      return 0;
   endfunction

   task automatic model();
      int nb, fid, gch, np;
      logic [3:0] exp_rdy;
      req_t r;
      rsp_t s;
      nb  = nbusy();
      fid = lowest_free();
      gch = -1;
      if (m_phase == 1 && !d_drain && nb < DEPTH && (!m_full || d_ready)) begin
         for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (m_ptr + i) % NUM_CH;
            if (gch < 0 && d_valid[c]) gch = c;
         end
      end
      exp_rdy = (gch >= 0) ? 4'(1 << gch) : 4'b0;
      chk("ch_req_ready", ch_req_ready, exp_rdy);
      chk("id_available", id_available, nb < DEPTH);
      if (nb < DEPTH) chk("next_id", next_id_available_out, fid);
      chk("outstanding_count", outstanding_count, nb);
      chk("drain_done", drain_done, m_phase == 3);
      chk("err_spurious_rsp", err_spurious_rsp, m_err);
      chk("mem_req_valid", mem_req_valid, m_full);
      if (m_was_reset) begin
         chk("reset_mem_req", mem_req, 0);
         chk("reset_mem_req_id", mem_req_id, 0);
         chk("reset_ch_rsp_valid", ch_rsp_valid, 0);
         chk("reset_ch_rsp_data", ch_rsp_data, 0);
         chk("reset_ch_rsp_rw", ch_rsp_rw, 0);
         m_was_reset = 0;
      end
      if (!d_reset) begin
         m_phase = 0; m_ptr = 0; m_full = 0; m_err = 0;
         for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
         q_req.delete();
         q_rsp.delete();
         m_was_reset = 1;
         return;
      end
      np = m_phase;
      case (m_phase)
         0: np = 1;
         1: if (d_drain) np = 2;
         2: if (nb == 0 && !m_full) np = 3;
         default: np = 3;
      endcase
      if (d_rsp_valid) begin
         if (m_busy[d_rsp_id]) begin
            s.ch = m_ch[d_rsp_id]; s.rw = m_rw[d_rsp_id]; s.data = d_rsp_data; s.due = cyc + 1;
            q_rsp.push_back(s);
            m_busy[d_rsp_id] = 0;
         end else begin
            m_err = 1;
         end
      end
      if (gch >= 0) begin
         r.req = {d_rw[gch], d_addr[gch], d_data[gch]};
         r.id  = 4'(fid);
         q_req.push_back(r);
         m_busy[fid] = 1; m_ch[fid] = gch; m_rw[fid] = d_rw[gch];
         m_ptr  = (gch + 1) % NUM_CH;
         m_full = 1;
         n_grants++;
      end else if (d_ready) begin
         m_full = 0;
      end
      m_phase = np;
   endtask

   task automatic step();
      @(negedge clk);
      reset         = d_reset;
      ch_req_valid  = d_valid;
      ch_req_rw     = d_rw;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_req_addr[i*ADDR_W +: ADDR_W] = d_addr[i];
         ch_req_data[i*DATA_W +: DATA_W] = d_data[i];
      end
      mem_req_ready = d_ready;
      mem_rsp_valid = d_rsp_valid;
      mem_rsp_id    = d_rsp_id;
      mem_rsp_data  = d_rsp_data;
      drain_req     = d_drain;
      #1;
      model();
   endtask

   task automatic idle();
      d_valid = '0; d_rsp_valid = 1'b0; d_drain = 1'b0; d_ready = 1'b1;
   endtask

   task automatic do_reset(input int n);
      idle();
      d_reset = 1'b0;
      repeat (n) step();
      d_reset = 1'b1;
   endtask

   task automatic respond(input int id, input logic [31:0] data);
      d_rsp_valid = 1'b1; d_rsp_id = 4'(id); d_rsp_data = data;
      step();
      d_rsp_valid = 1'b0;
   endtask

   task automatic wait_grants(input int n, input int max_cyc);
      int start, k;
      start = n_grants;
      k = 0;
      while (n_grants - start < n && k < max_cyc) begin
         step();
         k++;
      end
      chk("grant_count", n_grants - start, n);
   endtask

   task automatic randomize_payload();
      for (int i = 0; i < NUM_CH; i++) begin
         d_addr[i] = 31'($urandom);
         d_data[i] = $urandom;
      end
      d_rw = 4'($urandom);
   endtask

   // monitor: sampled just before each rising edge, independent of the driver
   logic        prev_hold = 1'b0;
   logic [63:0] prev_req = '0;
   logic [3:0]  prev_id = '0;
   initial begin
      req_t r;
      rsp_t s;
      forever begin
         @(negedge clk);
         #4;
         if (reset !== 1'b1) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", mem_req_valid, 1);
               chk("hold_req", mem_req, prev_req);
               chk("hold_id", mem_req_id, prev_id);
            end
            if (mem_req_valid && mem_req_ready) begin
               chk("req_expected", q_req.size() > 0, 1);
               if (q_req.size() > 0) begin
                  r = q_req.pop_front();
                  chk("mem_req", mem_req, r.req);
                  chk("mem_req_id", mem_req_id, r.id);
               end
            end
            prev_hold = mem_req_valid && !mem_req_ready;
            prev_req  = mem_req;
            prev_id   = mem_req_id;
            while (q_rsp.size() > 0 && q_rsp[0].due < cyc) begin
               s = q_rsp.pop_front();
               chk("rsp_missing", 0, 1 << s.ch);
            end
            if (ch_rsp_valid != 0) begin
               chk("rsp_expected", q_rsp.size() > 0, 1);
               if (q_rsp.size() > 0) begin
                  s = q_rsp.pop_front();
                  chk("ch_rsp_valid", ch_rsp_valid, 1 << s.ch);
                  chk("ch_rsp_data", ch_rsp_data, s.data);
                  chk("ch_rsp_rw", ch_rsp_rw, s.rw);
                  chk("rsp_latency", cyc, s.due);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ids [$];
      for (int i = 0; i < NUM_CH; i++) begin d_addr[i] = '0; d_data[i] = '0; end

      // single request from ch0
      do_reset(2);
      d_valid = 4'b0001; d_rw = 4'b0000; d_addr[0] = 31'h10; d_data[0] = 32'h0;
      wait_grants(1, 10);
      d_valid = '0;
      step();
      chk("single_mem_req", mem_req, 64'h0000_0010_0000_0000);
      chk("single_mem_req_id", mem_req_id, 0);
      chk("single_outstanding", outstanding_count, 1);
      respond(0, 32'hCAFE);
      step();
      chk("single_rsp_valid", ch_rsp_valid, 4'b0001);
      chk("single_rsp_data", ch_rsp_data, 32'hCAFE);
      step();
      chk("single_outstanding_after", outstanding_count, 0);

      // round-robin fill until every ID is busy
      do_reset(1);
      randomize_payload();
      d_valid = 4'hF;
      wait_grants(16, 40);
      step();
      step();
      chk("full_count", outstanding_count, 16);
      chk("full_avail", id_available, 0);
      chk("full_ready", ch_req_ready, 0);

      // backpressure on the memory side
      do_reset(1);
      randomize_payload();
      d_valid = 4'hF; d_ready = 1'b0;
      repeat (6) step();
      d_ready = 1'b1;
      wait_grants(4, 10);
      d_valid = '0;
      repeat (3) step();

      // out-of-order completion plus a spurious response
      do_reset(1);
      randomize_payload();
      d_valid = 4'b0100; wait_grants(1, 10);
      d_valid = 4'b0001; wait_grants(1, 10);
      d_valid = 4'b0010; wait_grants(1, 10);
      d_valid = '0;
      step(); step();
      respond(2, 32'h1111_2222);
      respond(0, 32'h3333_4444);
      respond(1, 32'h5555_6666);
      respond(5, 32'h7777_8888);
      step(); step();
      chk("ooo_err", err_spurious_rsp, 1);

      // orderly drain with three outstanding
      do_reset(1);
      randomize_payload();
      d_valid = 4'hF;
      wait_grants(3, 10);
      d_drain = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         respond(i, $urandom);
         step();
      end
      begin
         int k;
         k = 0;
         while (m_phase != 3 && k < 10) begin step(); k++; end
         chk("drain_reached", m_phase, 3);
      end
      d_drain = 1'b0;
      repeat (3) step();
      chk("drain_done_sticky", drain_done, 1);

      // reset with four outstanding, then a stale response
      do_reset(1);
      randomize_payload();
      d_valid = 4'hF;
      wait_grants(4, 10);
      d_valid = '0;
      step();
      do_reset(1);
      step();
      chk("rst_outstanding", outstanding_count, 0);
      respond(2, 32'hDEAD_BEEF);
      step();
      chk("rst_stale_err", err_spurious_rsp, 1);

      // randomized traffic ending in a drain
      do_reset(1);
      for (int c = 0; c < 900; c++) begin
         randomize_payload();
         d_valid = 4'($urandom);
         d_ready = ($urandom_range(3) != 0);
         d_drain = (c > 780);
         d_rsp_valid = 1'b0;
         ids.delete();
         for (int i = 0; i < DEPTH; i++) if (m_busy[i]) ids.push_back(i);
         if (ids.size() > 0 && $urandom_range(1) == 1) begin
            d_rsp_valid = 1'b1;
            d_rsp_id    = 4'(ids[$urandom_range(ids.size() - 1)]);
            d_rsp_data  = $urandom;
         end else if ($urandom_range(59) == 0) begin
            d_rsp_valid = 1'b1;
            d_rsp_id    = 4'($urandom);
            d_rsp_data  = $urandom;
         end
         step();
      end
      d_rsp_valid = 1'b0;
      repeat (3) step();
      chk("random_drained", drain_done, 1);

      idle();
      repeat (3) step();
      chk("req_queue_empty", q_req.size(), 0);
      chk("rsp_queue_empty", q_rsp.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
